// File: rtl/pipelined_array_mult_pkg.sv
// Shared definitions for the tiled array multiplier: tile-count and
// tile-shift helpers plus the default tile-product type.
package pipelined_array_mult_pkg;

    // Default tile width; the tile-product type below is sized from it.
    localparam int DEFAULT_SLICE = 4;

    typedef logic [2*DEFAULT_SLICE-1:0] tile_prod_t;

    // Number of SLICE-bit tiles per WIDTH-bit operand.
    function automatic int nt(input int width, input int slice);
        return width / slice;
    endfunction

    // Bit offset of tile (i,j) inside the full product.
    function automatic int tile_shift(input int slice, input int i, input int j);
        return slice * (i + j);
    endfunction

endpackage

// File: rtl/mult_tile.sv
// Combinational SLICE x SLICE unsigned multiplier; one tile of the array.
module mult_tile
    import pipelined_array_mult_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0]   x,
    input  logic [SLICE-1:0]   y,
    output logic [2*SLICE-1:0] prod
);

    // Both operands are zero-extended so the product is full width.
    assign prod = {{SLICE{1'b0}}, x} * {{SLICE{1'b0}}, y};

endmodule

// File: rtl/pipelined_array_mult.sv
// Pipelined WIDTH x WIDTH tiled array multiplier with valid/ready on both
// sides and a per-beat signed/unsigned mode.
// S1 registers the NT*NT tile products of the operand magnitudes, S2 sums
// them and restores the sign.
// Optional macro PIPELINED_ARRAY_MULT_ACC_EN adds a third stage with a
// running accumulator (ports acc_clr, acc).
//
// Handshake: a beat moves into a stage when that stage is empty or its
// contents leave in the same cycle; in_ready depends only on internal
// valid flags and out_ready, never on in_valid.
module pipelined_array_mult
    import pipelined_array_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               p_signed
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
    ,
    input  logic               acc_clr,
    output logic [2*WIDTH+7:0] acc
`endif
);

    localparam int NT = nt(WIDTH, SLICE);
    localparam int PW = 2 * WIDTH;
    localparam int TW = 2 * SLICE;

    logic [WIDTH-1:0]           mag_a;
    logic [WIDTH-1:0]           mag_b;
    logic                       neg_in;
    logic [NT*NT-1:0][TW-1:0]   tile_prod;

    logic                       s1_valid;
    logic                       s1_neg;
    logic                       s1_signed;
    logic [NT*NT-1:0][TW-1:0]   s1_tile;

    logic [PW-1:0]              sum;
    logic [PW-1:0]              res;
    logic                       adv1;
    logic                       adv2;

    // Operand magnitudes; the most-negative value negates to itself, which
    // read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        mag_a  = (is_signed && a[WIDTH-1]) ? (-a) : a;
        mag_b  = (is_signed && b[WIDTH-1]) ? (-b) : b;
        neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    for (genvar i = 0; i < NT; i++) begin : g_row
        for (genvar j = 0; j < NT; j++) begin : g_col
            mult_tile #(.SLICE(SLICE)) u_tile (
                .x    (mag_a[i*SLICE +: SLICE]),
                .y    (mag_b[j*SLICE +: SLICE]),
                .prod (tile_prod[i*NT+j])
            );
        end
    end

    // Shift-and-add of the registered tile products, then sign restore.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NT; i++) begin
            for (int j = 0; j < NT; j++) begin
                sum = sum + (PW'(s1_tile[i*NT+j]) << tile_shift(SLICE, i, j));
            end
        end
        res = s1_neg ? (-sum) : sum;
    end

`ifdef PIPELINED_ARRAY_MULT_ACC_EN
    logic            s1_clr;
    logic            s2_valid;
    logic            s2_signed;
    logic            s2_clr;
    logic [PW-1:0]   s2_p;
    logic [PW+7:0]   acc_add;
    logic            adv3;

    assign adv3 = !out_valid || out_ready;
    assign adv2 = !s2_valid || adv3;
`else
    assign adv2 = !out_valid || out_ready;
`endif
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // S1: capture tile products, sign flag and mode on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_neg    <= 1'b0;
            s1_signed <= 1'b0;
            s1_tile   <= '0;
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
            s1_clr    <= 1'b0;
`endif
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_neg    <= neg_in;
                s1_signed <= is_signed;
                s1_tile   <= tile_prod;
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
                s1_clr    <= acc_clr;
`endif
            end
        end
    end

`ifdef PIPELINED_ARRAY_MULT_ACC_EN
    // S2: register the finished product ahead of the accumulate stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_p      <= '0;
            s2_signed <= 1'b0;
            s2_clr    <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_p      <= res;
                s2_signed <= s1_signed;
                s2_clr    <= s1_clr;
            end
        end
    end

    // Signed beats extend with the product sign, unsigned beats with zeros.
    assign acc_add = s2_signed ? {{8{s2_p[PW-1]}}, s2_p} : {8'b0, s2_p};

    // S3: present the product and fold it into the accumulator together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
            p_signed  <= 1'b0;
            acc       <= '0;
        end else if (adv3) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                p        <= s2_p;
                p_signed <= s2_signed;
                acc      <= s2_clr ? acc_add : (acc + acc_add);
            end
        end
    end
`else
    // S2: register the signed product as the block output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
            p_signed  <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                p        <= res;
                p_signed <= s1_signed;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_array_mult.sv
// Self-checking bench for pipelined_array_mult: three instances
// (8/4, 16/4, 12/4) driven from one process; inputs change 1 time unit
// after the rising edge, outputs and handshakes are sampled on the falling
// edge. Expected products come from plain integer multiplication.
module tb_pipelined_array_mult;

`ifdef PIPELINED_ARRAY_MULT_ACC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;

    logic        in_valid8, in_ready8, s8, out_valid8, out_ready8, ps8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        in_valid16, in_ready16, s16, out_valid16, out_ready16, ps16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        in_valid12, in_ready12, s12, out_valid12, out_ready12, ps12;
    logic [11:0] a12, b12;
    logic [23:0] p12;
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
    logic        acc_clr8;
    logic [23:0] acc8;
    logic [39:0] acc16;
    logic [31:0] acc12;
    logic [23:0] acc_m8;
    bit          clr_q8[$];
`endif

    int checks;
    int errors;
    int pops8;
    bit accepted8, accepted16, accepted12;
    bit stall8;
    logic [15:0] hold_p8;

    logic [16:0] exp_q8[$];
    logic [32:0] exp_q16[$];
    logic [24:0] exp_q12[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          s;
        logic [15:0] p;
    } vec_t;
    localparam int NV = 9;
    vec_t vecs[NV];

    pipelined_array_mult #(.WIDTH(8), .SLICE(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(s8), .out_valid(out_valid8),
        .out_ready(out_ready8), .p(p8), .p_signed(ps8)
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
        , .acc_clr(acc_clr8), .acc(acc8)
`endif
    );

    pipelined_array_mult #(.WIDTH(16), .SLICE(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .is_signed(s16), .out_valid(out_valid16),
        .out_ready(out_ready16), .p(p16), .p_signed(ps16)
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
        , .acc_clr(1'b0), .acc(acc16)
`endif
    );

    pipelined_array_mult #(.WIDTH(12), .SLICE(4)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12),
        .a(a12), .b(b12), .is_signed(s12), .out_valid(out_valid12),
        .out_ready(out_ready12), .p(p12), .p_signed(ps12)
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
        , .acc_clr(1'b0), .acc(acc12)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit in case something blocks unexpectedly.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands as integers and multiply, keep 2w bits.
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] x,
                                             input logic [31:0] y, input bit s);
        longint vx;
        longint vy;
        longint prod;
        vx = longint'(x);
        vy = longint'(y);
        if (s && x[w-1]) vx = vx - (longint'(1) << w);
        if (s && y[w-1]) vy = vy - (longint'(1) << w);
        prod = vx * vy;
        return 64'(prod) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Falling-edge sample: scoreboard pops/pushes and protocol checks.
    task automatic sample();
        logic [63:0] r;
        logic [16:0] e8;
        logic [32:0] e16;
        logic [24:0] e12;
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
        bit          clr;
        logic [23:0] ext;
`endif
        @(negedge clk);
        accepted8  = 1'b0;
        accepted16 = 1'b0;
        accepted12 = 1'b0;
        if (rst) begin
            exp_q8.delete();
            exp_q16.delete();
            exp_q12.delete();
            stall8 = 1'b0;
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
            clr_q8.delete();
            acc_m8 = '0;
`endif
            return;
        end
        // in_ready low only when every stage holds a beat and output stalls
        chk("in_ready8", 64'(in_ready8), 64'(!(exp_q8.size() == LAT && !out_ready8)));
        if (stall8) begin
            chk("stall_valid8", 64'(out_valid8), 64'd1);
            chk("stall_p8", 64'(p8), 64'(hold_p8));
        end
        stall8  = out_valid8 && !out_ready8;
        hold_p8 = p8;

        if (out_valid8 && out_ready8) begin
            pops8++;
            if (exp_q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out8: got %0h expected none", p8);
            end else begin
                e8 = exp_q8.pop_front();
                chk("p8", 64'({ps8, p8}), 64'(e8));
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
                clr    = clr_q8.pop_front();
                ext    = e8[16] ? {{8{e8[15]}}, e8[15:0]} : {8'b0, e8[15:0]};
                acc_m8 = clr ? ext : (acc_m8 + ext);
                chk("acc8", 64'(acc8), 64'(acc_m8));
`endif
            end
        end
        if (out_valid16 && out_ready16) begin
            if (exp_q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out16: got %0h expected none", p16);
            end else begin
                e16 = exp_q16.pop_front();
                chk("p16", 64'({ps16, p16}), 64'(e16));
            end
        end
        if (out_valid12 && out_ready12) begin
            if (exp_q12.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out12: got %0h expected none", p12);
            end else begin
                e12 = exp_q12.pop_front();
                chk("p12", 64'({ps12, p12}), 64'(e12));
            end
        end

        if (in_valid8 && in_ready8) begin
            accepted8 = 1'b1;
            r = ref_prod(8, {24'b0, a8}, {24'b0, b8}, s8);
            exp_q8.push_back({s8, r[15:0]});
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
            clr_q8.push_back(acc_clr8);
`endif
        end
        if (in_valid16 && in_ready16) begin
            accepted16 = 1'b1;
            r = ref_prod(16, {16'b0, a16}, {16'b0, b16}, s16);
            exp_q16.push_back({s16, r[31:0]});
        end
        if (in_valid12 && in_ready12) begin
            accepted12 = 1'b1;
            r = ref_prod(12, {20'b0, a12}, {20'b0, b12}, s12);
            exp_q12.push_back({s12, r[23:0]});
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    // One isolated 8-bit beat with exact-latency and constant-result checks.
    task automatic lat_beat(input logic [7:0] x, input logic [7:0] y, input bit s,
                            input logic [15:0] exp);
        a8 = x; b8 = y; s8 = s; in_valid8 = 1'b1; out_ready8 = 1'b1;
        sample();
        chk("lat_accept", 64'(in_ready8), 64'd1);
        advance();
        in_valid8 = 1'b0;
        for (int m = 1; m <= LAT; m++) begin
            sample();
            chk("lat_valid", 64'(out_valid8), 64'(m == LAT));
            if (m == LAT) begin
                chk("lat_p", 64'(p8), 64'(exp));
                chk("lat_ps", 64'(ps8), 64'(s));
            end
            advance();
        end
    endtask

    function automatic logic [7:0] rnd8();
        return ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
    endfunction

    initial begin
        int n_acc;
        int pops_start;
        bit pat[4];

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[3] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vecs[4] = '{8'h00, 8'h85, 1'b1, 16'h0000};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[6] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        vecs[7] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[8] = '{8'h85, 8'h00, 1'b1, 16'h0000};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        checks = 0; errors = 0; pops8 = 0; stall8 = 1'b0; hold_p8 = '0;
        rst = 1'b1;
        in_valid8 = 0; a8 = 0; b8 = 0; s8 = 0; out_ready8 = 0;
        in_valid16 = 0; a16 = 0; b16 = 0; s16 = 0; out_ready16 = 1;
        in_valid12 = 0; a12 = 0; b12 = 0; s12 = 0; out_ready12 = 1;
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
        acc_clr8 = 0; acc_m8 = '0;
`endif

        // Reset and reset values
        advance();
        repeat (3) cycle();
        sample();
        chk("rst_out_valid", 64'(out_valid8), 64'd0);
        chk("rst_p", 64'(p8), 64'd0);
        chk("rst_p_signed", 64'(ps8), 64'd0);
`ifdef PIPELINED_ARRAY_MULT_ACC_EN
        chk("rst_acc", 64'(acc8), 64'd0);
`endif
        advance();
        rst = 1'b0;
        sample();
        chk("post_rst_in_ready", 64'(in_ready8), 64'd1);
        advance();

        // First beat latency
        lat_beat(8'hFF, 8'hFF, 1'b0, 16'hFE01);

        // Back-to-back table, one result per cycle in order
        for (int t = 0; t < NV + LAT; t++) begin
            if (t < NV) begin
                a8 = vecs[t].a; b8 = vecs[t].b; s8 = vecs[t].s; in_valid8 = 1'b1;
            end else begin
                in_valid8 = 1'b0;
            end
            out_ready8 = 1'b1;
            sample();
            if (t >= LAT) begin
                chk("tbl_valid", 64'(out_valid8), 64'd1);
                chk("tbl_p", 64'(p8), 64'(vecs[t-LAT].p));
                chk("tbl_ps", 64'(ps8), 64'(vecs[t-LAT].s));
            end
            advance();
        end

        // Backpressure: 10 random beats, out_ready in a 1-0-0-1 pattern
        n_acc = 0;
        pops_start = pops8;
        a8 = rnd8(); b8 = rnd8(); s8 = 1'($urandom); in_valid8 = 1'b1;
        for (int c = 0; c < 200 && (n_acc < 10 || exp_q8.size() != 0); c++) begin
            out_ready8 = pat[c % 4];
            cycle();
            if (accepted8) begin
                n_acc++;
                if (n_acc < 10) begin
                    a8 = rnd8(); b8 = rnd8(); s8 = 1'($urandom);
                end else begin
                    in_valid8 = 1'b0;
                end
            end
        end
        chk("bp_accepted", 64'(n_acc), 64'd10);
        chk("bp_popped", 64'(pops8 - pops_start), 64'd10);
        chk("bp_drained", 64'(exp_q8.size()), 64'd0);

        // Reset with two beats in flight
        out_ready8 = 1'b0;
        a8 = 8'd11; b8 = 8'd13; s8 = 1'b0; in_valid8 = 1'b1;
        cycle();
        a8 = 8'hF0; b8 = 8'h21; s8 = 1'b1;
        cycle();
        in_valid8 = 1'b0;
        repeat (LAT - 1) cycle();
        sample();
        chk("mid_full", 64'(out_valid8), 64'd1);
        advance();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sample();
        chk("mid_flush_valid", 64'(out_valid8), 64'd0);
        advance();
        out_ready8 = 1'b1;
        repeat (4) cycle();
        chk("mid_no_ghost", 64'(pops8 - pops_start), 64'd10);
        lat_beat(8'd9, 8'd7, 1'b0, 16'd63);

        // 16-bit most-negative squared
        a16 = 16'h8000; b16 = 16'h8000; s16 = 1'b1; in_valid16 = 1'b1; out_ready16 = 1'b1;
        cycle();
        in_valid16 = 1'b0;
        for (int m = 1; m <= LAT; m++) begin
            sample();
            if (m == LAT) begin
                chk("w16_valid", 64'(out_valid16), 64'd1);
                chk("w16_p", 64'(p16), 64'h40000000);
            end
            advance();
        end

        // Random traffic on all three widths with random backpressure
        for (int c = 0; c < 300; c++) begin
            if (!in_valid8 || accepted8) begin
                in_valid8 = ($urandom_range(0, 3) != 0);
                a8 = rnd8(); b8 = rnd8(); s8 = 1'($urandom);
            end
            if (!in_valid16 || accepted16) begin
                in_valid16 = ($urandom_range(0, 3) != 0);
                a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
            end
            if (!in_valid12 || accepted12) begin
                in_valid12 = ($urandom_range(0, 3) != 0);
                a12 = 12'($urandom); b12 = 12'($urandom); s12 = 1'($urandom);
            end
            out_ready8  = ($urandom_range(0, 3) != 0);
            out_ready16 = ($urandom_range(0, 3) != 0);
            out_ready12 = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid8 = 0; in_valid16 = 0; in_valid12 = 0;
        out_ready8 = 1; out_ready16 = 1; out_ready12 = 1;
        for (int c = 0; c < 20 && (exp_q8.size() + exp_q16.size() + exp_q12.size()) != 0; c++)
            cycle();
        chk("rnd_drained8", 64'(exp_q8.size()), 64'd0);
        chk("rnd_drained16", 64'(exp_q16.size()), 64'd0);
        chk("rnd_drained12", 64'(exp_q12.size()), 64'd0);

`ifdef PIPELINED_ARRAY_MULT_ACC_EN
        // Accumulator: 3*4 with clear, then 5*6, then (-2)*7
        begin
            logic [7:0]  xa[3];
            logic [7:0]  xb[3];
            logic [23:0] xacc[3];
            xa = '{8'd3, 8'd5, 8'hFE};
            xb = '{8'd4, 8'd6, 8'd7};
            xacc = '{24'd12, 24'd42, 24'd28};
            out_ready8 = 1'b1;
            for (int t = 0; t < 3 + LAT; t++) begin
                if (t < 3) begin
                    a8 = xa[t]; b8 = xb[t]; s8 = 1'b1; acc_clr8 = (t == 0); in_valid8 = 1'b1;
                end else begin
                    in_valid8 = 1'b0; acc_clr8 = 1'b0;
                end
                sample();
                if (t >= LAT) begin
                    chk("acc_valid", 64'(out_valid8), 64'd1);
                    chk("acc_value", 64'(acc8), 64'(xacc[t-LAT]));
                end
                advance();
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
